// File: rtl/pc_unit.sv
// pc_unit: IF-stage word-addressed PC with seq/branch/jump/call/ret updates and a circular return-address stack
module pc_unit #(
  parameter int ADDR_W = 13,
  parameter int RAS_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           en,
  input  logic [2:0]                     op,
  input  logic [ADDR_W-1:0]              offset,
  input  logic [ADDR_W-1:0]              target,
  output logic [ADDR_W-1:0]              pc,
  output logic [ADDR_W-1:0]              pc_plus1,
  output logic [$clog2(RAS_DEPTH):0]     ras_count,
  output logic                           ras_full,
  output logic                           ras_empty,
  output logic                           ras_err
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;
  typedef enum logic [2:0] {
    OP_HOLD, OP_SEQ, OP_BRANCH, OP_JUMP, OP_CALL, OP_RET, OP_RESTART, OP_RSVD
  } op_t;
  logic [ADDR_W-1:0] stack [RAS_DEPTH];
  logic [PW-1:0]     wp, wp_n, top;
  logic [ADDR_W-1:0] pc_n;
  logic [CW-1:0]     cnt_n;
  logic              err_n, push;
  assign pc_plus1  = pc + 1'b1;
  assign ras_full  = ras_count == CW'(RAS_DEPTH);
  assign ras_empty = ras_count == '0;
  assign top       = wp - 1'b1;
  always_comb begin
    pc_n  = pc;
    cnt_n = ras_count;
    wp_n  = wp;
    err_n = ras_err;
    push  = 1'b0;
    if (en) begin
      case (op_t'(op))
        OP_SEQ:     pc_n = pc_plus1;
        OP_BRANCH:  pc_n = pc + offset;
        OP_JUMP:    pc_n = target;
        OP_CALL: begin
          push  = 1'b1;
          pc_n  = target;
          wp_n  = wp + 1'b1;
          cnt_n = ras_full ? ras_count : ras_count + 1'b1;
          err_n = ras_err | ras_full;
        end
        OP_RET: begin
          err_n = ras_err | ras_empty;
          pc_n  = ras_empty ? pc : stack[top];
          wp_n  = ras_empty ? wp : top;
          cnt_n = ras_empty ? ras_count : ras_count - 1'b1;
        end
        OP_RESTART: begin
          pc_n  = RESET_PC;
          cnt_n = '0;
          wp_n  = '0;
          err_n = 1'b0;
        end
        default:    pc_n = pc;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pc        <= RESET_PC;
      ras_count <= '0;
      wp        <= '0;
      ras_err   <= 1'b0;
    end else begin
      pc        <= pc_n;
      ras_count <= cnt_n;
      wp        <= wp_n;
      ras_err   <= err_n;
    end
  end
  // a full stack wraps wp onto the oldest slot, so overflow overwrites it for free
  always_ff @(posedge clk)
    if (push && !reset) stack[wp] <= pc_plus1;
endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the IF stage of the MUSA core. It replaces the fixed 13-bit load-only PC with a word-addressed counter of configurable width. The counter supports sequential, relative-branch, absolute-jump, call and return updates. A hardware return-address stack of configurable depth backs call and return, and status flags report stack occupancy and misuse. Its output drives the instruction-memory address; its control inputs come from the decode/control unit.

## Interface
Parameters:
- ADDR_W, 13, PC and address width in bits (word address)
- RAS_DEPTH, 4, return-address stack entries (power of two, ≥2)
- RESET_PC, 0, PC value after reset and after RESTART

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- en  in  1  update enable; 0 = stall, no state changes
- op  in  3  update operation (encoding below)
- offset  in  ADDR_W  signed two's-complement branch displacement, in words
- target  in  ADDR_W  absolute jump/call destination
- pc  out  ADDR_W  current PC, registered
- pc_plus1  out  ADDR_W  pc + 1 mod 2^ADDR_W, combinational from pc
- ras_count  out  $clog2(RAS_DEPTH)+1  valid stack entries, registered
- ras_full  out  1  ras_count == RAS_DEPTH
- ras_empty  out  1  ras_count == 0
- ras_err  out  1  sticky misuse flag, registered

## Operation
- Reset is synchronous, active-high, and has priority over en.
- Reset values: pc=RESET_PC, ras_count=0, ras_err=0, ras_empty=1, ras_full=0. Stack contents are don't-care.
- When en=0, the block holds all registers; op, offset and target are ignored.
- When en=1, the op encoding is:
  - 000 HOLD: pc unchanged.
  - 001 SEQ: pc ← pc+1.
  - 010 BRANCH: pc ← pc + sign-extended offset.
  - 011 JUMP: pc ← target.
  - 100 CALL: push pc+1 onto the stack; pc ← target.
  - 101 RET: pop the top of the stack into pc.
  - 110 RESTART: pc ← RESET_PC; ras_count ← 0; ras_err ← 0.
  - 111 reserved: behaves as HOLD.
- All PC arithmetic is modulo 2^ADDR_W. Overflow and underflow wrap silently; for example, with ADDR_W=13, 8191+1 = 0.
- The stack is a circular buffer with a top pointer and ras_count.
- CALL on a full stack overwrites the oldest entry. ras_count stays at RAS_DEPTH, ras_err is set, and the jump still happens.
- RET on an empty stack leaves pc unchanged and sets ras_err. ras_count stays 0.
- ras_err stays set until reset or RESTART.
- CALL writes pc+1 computed from the current registered pc, never from target.
- RET returns the most recently pushed surviving entry (LIFO). After an overflow, at most RAS_DEPTH returns yield valid addresses.

## Timing
- Single-cycle update: inputs sampled at edge N appear on pc, ras_count, the flags and ras_err right after edge N.
- No internal pipelining. A CALL followed by a RET on the next cycle returns the address pushed by that CALL.
- pc_plus1 is valid in the same cycle as pc, with zero latency.
- Reset asserted mid-stall, or in the same cycle as any op, wins: state goes to reset values on that edge.
- ras_full and ras_empty are decoded from the registered ras_count and are glitch-free relative to it.

## Test plan
- **Reset and stall:** assert reset, then release and hold en=0 with op=001 for 5 cycles → pc=0 and ras_empty=1 throughout. Then SEQ ×3 → pc=3.
- **Wrap-around:** JUMP target=8190, then SEQ ×2 → pc=8191, then 0. Then BRANCH offset=−1 (13'h1FFF) → pc=8191.
- **Call/return:**
  - At pc=10, CALL target=100 → pc=100, ras_count=1.
  - At pc=100, CALL target=200 → pc=200, ras_count=2.
  - RET → pc=101.
  - RET → pc=11, ras_empty=1, ras_err=0.
- **Overflow:** 5 nested CALLs with RAS_DEPTH=4 → ras_full=1 after the 4th, ras_err=1 after the 5th. Four RETs then return the return addresses of calls 5, 4, 3, 2 in that order.
- **Underflow and clear:**
  - RET on an empty stack at pc=42 → pc stays 42, ras_err=1.
  - RESTART → pc=0, ras_err=0, ras_count=0.
- **Reset priority:** with ras_count=2, drive reset=1 together with en=1 and op=100 target=77 → pc=0 and ras_count=0 after the edge.
